// File: rtl/fir_filter_mc_if.sv
// rtl/fir_filter_mc_if.sv - bus bundle for the multi-channel serial-MAC FIR filter
// Signals:
//   init_filter, coeff_in, coeff_valid    coefficient reload request and words (tap 0 first)
//   init_in_progress                      high while the coefficient bank is being loaded
//   in_data, in_channel, in_valid/ready   sample input handshake
//   out_data, out_channel, out_valid      one-cycle result strobe tagged with channel
//   chan_err                              one-cycle pulse for a dropped out-of-range channel
// Modports: master = source/consumer side, slave = filter side.
interface fir_filter_mc_if #(
    parameter int DATA_W  = 16,
    parameter int COEFF_W = 16,
    parameter int CH_W    = 1,
    parameter int OUT_W   = 36
);
    logic               init_filter;
    logic [COEFF_W-1:0] coeff_in;
    logic               coeff_valid;
    logic               init_in_progress;
    logic [DATA_W-1:0]  in_data;
    logic [CH_W-1:0]    in_channel;
    logic               in_valid;
    logic               in_ready;
    logic [OUT_W-1:0]   out_data;
    logic [CH_W-1:0]    out_channel;
    logic               out_valid;
    logic               chan_err;

    modport master (
        output init_filter, coeff_in, coeff_valid, in_data, in_channel, in_valid,
        input  in_ready, out_data, out_channel, out_valid, chan_err, init_in_progress
    );

    modport slave (
        input  init_filter, coeff_in, coeff_valid, in_data, in_channel, in_valid,
        output in_ready, out_data, out_channel, out_valid, chan_err, init_in_progress
    );
endinterface

// File: rtl/fir_filter_mc.sv
// rtl/fir_filter_mc.sv - multi-channel serial-MAC FIR filter with shared coefficient bank
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-low reset
//   bus  fir_filter_mc_if.slave: coefficient load, sample input handshake,
//        tagged result strobe, chan_err and init_in_progress
// One multiply-accumulate per clock; a sample takes TAPS+2 cycles from
// acceptance to the next possible acceptance.
module fir_filter_mc #(
    parameter int DATA_W   = 16,
    parameter int COEFF_W  = 16,
    parameter int TAPS     = 16,
    parameter int CHANNELS = 2,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int OUT_W    = DATA_W + COEFF_W + $clog2(TAPS)
) (
    input  logic           clk,
    input  logic           rst,
    fir_filter_mc_if.slave bus
);
    localparam int TAP_W  = $clog2(TAPS);
    localparam int CIDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);
    localparam logic [TAP_W-1:0] TAPS_MOD = TAP_W'(TAPS);
    localparam logic [TAP_W-1:0] ONE_TAP  = TAP_W'(1);

    typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} state_t;

    state_t state_q, state_d;

    // Low for the first cycle after reset so in_ready comes out of reset at 0.
    logic               alive_q;
    logic [COEFF_W-1:0] coeff_q [TAPS];
    logic [DATA_W-1:0]  delay_q [CHANNELS][TAPS];
    logic [TAP_W-1:0]   head_q  [CHANNELS];
    logic [TAP_W-1:0]   idx_q;
    logic [TAP_W-1:0]   k_q;
    logic [CH_W-1:0]    ch_q;
    logic [OUT_W-1:0]   acc_q;
    logic [OUT_W-1:0]   out_data_q;
    logic [CH_W-1:0]    out_channel_q;
    logic               out_valid_q;
    logic               chan_err_q;

    logic in_ready_c, accept, drop, load_start, coeff_wr, load_last, mac_step, done_step;
    logic ch_ok;
    logic [CIDX_W-1:0] in_sel, cur_sel;
    logic [TAP_W-1:0]  cur_head, rd_idx;
    logic signed [DATA_W-1:0]  rd_sample;
    logic signed [COEFF_W-1:0] rd_coeff;
    logic signed [OUT_W-1:0]   samp_ext, coeff_ext, prod;

    assign ch_ok   = int'(bus.in_channel) < CHANNELS;
    assign in_sel  = CIDX_W'(bus.in_channel);
    assign cur_sel = CIDX_W'(ch_q);

    // Tap k reads the sample k positions older than the newest one; the
    // explicit wrap keeps the index inside 0..TAPS-1 for any TAPS.
    assign cur_head  = head_q[cur_sel];
    assign rd_idx    = (cur_head >= k_q) ? (cur_head - k_q) : (cur_head - k_q + TAPS_MOD);
    assign rd_sample = delay_q[cur_sel][rd_idx];
    assign rd_coeff  = coeff_q[k_q];
    assign samp_ext  = OUT_W'(rd_sample);
    assign coeff_ext = OUT_W'(rd_coeff);
    assign prod      = samp_ext * coeff_ext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        accept     = 1'b0;
        drop       = 1'b0;
        load_start = 1'b0;
        coeff_wr   = 1'b0;
        load_last  = 1'b0;
        mac_step   = 1'b0;
        done_step  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (alive_q) begin
                    if (bus.init_filter) begin
                        load_start = 1'b1;
                        state_d    = LOAD;
                    end else begin
                        in_ready_c = 1'b1;
                        if (bus.in_valid) begin
                            if (ch_ok) begin
                                accept  = 1'b1;
                                state_d = MAC;
                            end else begin
                                drop = 1'b1;
                            end
                        end
                    end
                end
            end
            LOAD: begin
                if (bus.coeff_valid) begin
                    coeff_wr = 1'b1;
                    if (idx_q == LAST_TAP) begin
                        load_last = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            MAC: begin
                mac_step = 1'b1;
                if (k_q == LAST_TAP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_step = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alive_q       <= 1'b0;
            idx_q         <= '0;
            k_q           <= '0;
            ch_q          <= '0;
            acc_q         <= '0;
            out_data_q    <= '0;
            out_channel_q <= '0;
            out_valid_q   <= 1'b0;
            chan_err_q    <= 1'b0;
            for (int t = 0; t < TAPS; t++) begin
                coeff_q[t] <= '0;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                head_q[c] <= '0;
                for (int t = 0; t < TAPS; t++) begin
                    delay_q[c][t] <= '0;
                end
            end
        end else begin
            alive_q     <= 1'b1;
            out_valid_q <= done_step;
            chan_err_q  <= drop;
            if (load_start) begin
                idx_q <= '0;
            end
            if (coeff_wr) begin
                coeff_q[idx_q] <= bus.coeff_in;
                idx_q          <= idx_q + ONE_TAP;
                // A new coefficient set invalidates every channel's history.
                if (load_last) begin
                    idx_q <= '0;
                    for (int c = 0; c < CHANNELS; c++) begin
                        head_q[c] <= '0;
                        for (int t = 0; t < TAPS; t++) begin
                            delay_q[c][t] <= '0;
                        end
                    end
                end
            end
            if (accept) begin
                ch_q                           <= bus.in_channel;
                delay_q[in_sel][head_q[in_sel]] <= bus.in_data;
                acc_q                          <= '0;
                k_q                            <= '0;
            end
            if (mac_step) begin
                acc_q <= acc_q + prod;
                k_q   <= k_q + ONE_TAP;
            end
            if (done_step) begin
                out_data_q      <= acc_q;
                out_channel_q   <= ch_q;
                head_q[cur_sel] <= (cur_head == LAST_TAP) ? '0 : cur_head + ONE_TAP;
            end
        end
    end

    assign bus.in_ready         = in_ready_c;
    assign bus.out_data         = out_data_q;
    assign bus.out_channel      = out_channel_q;
    assign bus.out_valid        = out_valid_q;
    assign bus.chan_err         = chan_err_q;
    assign bus.init_in_progress = (state_q == LOAD);
endmodule

// File: tb/tb_fir_filter_mc.sv
// tb/tb_fir_filter_mc.sv - scoreboard bench for fir_filter_mc against a direct-form FIR model
module tb_fir_filter_mc;
    localparam int DATA_W   = 16;
    localparam int COEFF_W  = 16;
    localparam int TAPS     = 16;
    localparam int CHANNELS = 2;
    localparam int CH_W     = 2;
    localparam int OUT_W    = DATA_W + COEFF_W + $clog2(TAPS);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fir_filter_mc_if #(.DATA_W(DATA_W), .COEFF_W(COEFF_W), .CH_W(CH_W), .OUT_W(OUT_W)) bus ();

    fir_filter_mc #(
        .DATA_W(DATA_W), .COEFF_W(COEFF_W), .TAPS(TAPS),
        .CHANNELS(CHANNELS), .CH_W(CH_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int coef_m [TAPS];
    int hist_m [CHANNELS][TAPS];
    int nc     [TAPS];

    logic [OUT_W-1:0] exp_val[$];
    int               exp_ch[$];
    int               exp_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) coef_m[k] = 0;
        for (int c = 0; c < CHANNELS; c++)
            for (int k = 0; k < TAPS; k++) hist_m[c][k] = 0;
        exp_val.delete();
        exp_ch.delete();
        exp_cyc.delete();
    endtask

    // y = sum over k of x[n-k] * h[k], newest sample at history position 0.
    task automatic model_accept(input int ch, input int d);
        longint s;
        for (int k = TAPS - 1; k > 0; k--) hist_m[ch][k] = hist_m[ch][k-1];
        hist_m[ch][0] = d;
        s = 0;
        for (int k = 0; k < TAPS; k++) s += longint'(hist_m[ch][k]) * longint'(coef_m[k]);
        exp_val.push_back(OUT_W'(s));
        exp_ch.push_back(ch);
        exp_cyc.push_back(cyc);
    endtask

    always @(negedge clk) begin : monitor
        logic [OUT_W-1:0] v;
        int c;
        int t;
        if (bus.out_valid === 1'b1) begin
            if (exp_val.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got data %0h ch %0d, required no output", bus.out_data, bus.out_channel);
            end else begin
                v = exp_val.pop_front();
                c = exp_ch.pop_front();
                t = exp_cyc.pop_front();
                chk("out_data", 64'(bus.out_data), 64'(v));
                chk("out_channel", 64'(bus.out_channel), 64'(c));
                chk("out_latency", 64'(cyc - t), 64'(TAPS + 2));
            end
        end
    end

    task automatic drain();
        int t;
        t = 0;
        while (exp_val.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_val.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_val.size());
            exp_val.delete();
            exp_ch.delete();
            exp_cyc.delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.init_filter = 1'b0;
        bus.in_valid    = 1'b0;
        bus.coeff_valid = 1'b0;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_data", 64'(bus.out_data), 64'(0));
        chk("rst_out_channel", 64'(bus.out_channel), 64'(0));
        chk("rst_chan_err", 64'(bus.chan_err), 64'(0));
        chk("rst_init_in_progress", 64'(bus.init_in_progress), 64'(0));
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ready_after_reset", 64'(bus.in_ready), 64'(1));
    endtask

    task automatic send(input int ch, input int d);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b1;
        bus.in_data    = DATA_W'(d);
        bus.in_channel = CH_W'(ch);
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                if (ch < CHANNELS) model_accept(ch, d);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: ch %0d not accepted, required acceptance", ch);
        end else begin
            @(negedge clk);
            if (ch >= CHANNELS) begin
                chk("chan_err_pulse", 64'(bus.chan_err), 64'(1));
                chk("idle_after_drop", 64'(bus.in_ready), 64'(1));
            end else begin
                chk("busy_after_accept", 64'(bus.in_ready), 64'(0));
                chk("no_chan_err", 64'(bus.chan_err), 64'(0));
            end
        end
    endtask

    // Loads nc[0..n_words-1]; a full load updates the model, a partial one leaves it to reset.
    task automatic load(input bit gaps, input bit with_sample, input int d, input int n_words);
        bit ok;
        ok = 1'b0;
        drain();
        @(posedge clk);
        #1;
        bus.init_filter = 1'b1;
        if (with_sample) begin
            bus.in_valid   = 1'b1;
            bus.in_data    = DATA_W'(d);
            bus.in_channel = '0;
        end
        @(negedge clk);
        chk("ready_low_on_init", 64'(bus.in_ready), 64'(0));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (bus.init_in_progress === 1'b1) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        bus.init_filter = 1'b0;
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL load_timeout: init_in_progress 0, required 1");
            return;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < n_words; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.coeff_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            bus.coeff_valid = 1'b1;
            bus.coeff_in    = COEFF_W'(nc[i]);
            @(negedge clk);
            if (i == TAPS - 1) chk("iip_last_write", 64'(bus.init_in_progress), 64'(1));
            @(posedge clk);
            #1;
        end
        bus.coeff_valid = 1'b0;
        if (n_words < TAPS) return;
        @(negedge clk);
        chk("iip_after_load", 64'(bus.init_in_progress), 64'(0));
        chk("ready_after_load", 64'(bus.in_ready), 64'(1));
        for (int k = 0; k < TAPS; k++) coef_m[k] = nc[k];
        for (int c = 0; c < CHANNELS; c++)
            for (int k = 0; k < TAPS; k++) hist_m[c][k] = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.init_filter = 1'b0;
        bus.coeff_in    = '0;
        bus.coeff_valid = 1'b0;
        bus.in_data     = '0;
        bus.in_channel  = '0;
        bus.in_valid    = 1'b0;
        do_reset();

        // Impulse response with coefficients 1..16.
        for (int k = 0; k < TAPS; k++) nc[k] = k + 1;
        load(1'b0, 1'b0, 0, TAPS);
        send(0, 1);
        for (int i = 0; i < TAPS - 1; i++) send(0, 0);

        // Unit coefficients, interleaved channels.
        for (int k = 0; k < TAPS; k++) nc[k] = 1;
        load(1'b1, 1'b0, 0, TAPS);
        for (int i = 0; i < 10; i++) begin
            send(0, 3);
            send(1, -2);
        end

        // Out-of-range channel is dropped; channels keep their history.
        send(3, 1234);
        send(2, -77);
        send(0, 3);
        send(1, -2);

        // Extreme operands: 16 x (-32768 * -32768) = 2^34.
        for (int k = 0; k < TAPS; k++) nc[k] = -32768;
        load(1'b0, 1'b0, 0, TAPS);
        for (int i = 0; i < TAPS; i++) send(0, -32768);

        // init_filter wins over a simultaneous sample, which then meets cleared history.
        for (int k = 0; k < TAPS; k++) nc[k] = int'($urandom_range(0, 65535)) - 32768;
        load(1'b1, 1'b1, 1111, TAPS);
        send(0, 1111);

        // Random traffic including invalid channels.
        for (int i = 0; i < 40; i++) begin
            send(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)) - 32768);
        end
        drain();

        // Reset during MAC at k=7.
        for (int k = 0; k < TAPS; k++) nc[k] = k + 1;
        load(1'b0, 1'b0, 0, TAPS);
        send(0, 5);
        repeat (7) @(posedge clk);
        #1;
        do_reset();

        // Reset during a partial load leaves all coefficients at zero.
        for (int k = 0; k < TAPS; k++) nc[k] = 100 + k;
        load(1'b0, 1'b0, 0, 5);
        do_reset();
        send(0, 1);
        send(1, 1);
        send(0, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
